// File: rtl/flash_rom_pkg.sv
// rtl/flash_rom_pkg.sv - shared widths and FSM state type for the flash ROM word cache
package flash_rom_pkg;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ISSUE,
    WAIT,
    FILL
  } state_t;
endpackage

// File: rtl/rom_cache_mem.sv
// rtl/rom_cache_mem.sv - direct-mapped data+tag store with a valid vector, one write port, one async read
module rom_cache_mem
  import flash_rom_pkg::*;
#(
  parameter int LINE_BITS = 4,
  parameter int TAG_W     = ADDR_W - LINE_BITS
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_clear,
  input  logic                 i_we,
  input  logic [LINE_BITS-1:0] i_w_idx,
  input  logic [TAG_W-1:0]     i_w_tag,
  input  logic [DATA_W-1:0]    i_w_data,
  input  logic [LINE_BITS-1:0] i_r_idx,
  output logic                 o_r_valid,
  output logic [TAG_W-1:0]     o_r_tag,
  output logic [DATA_W-1:0]    o_r_data
);
  localparam int LINES = 1 << LINE_BITS;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  // Clear beats a same-cycle write so an invalidated fill never becomes visible.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= '0;
    end else if (i_clear) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_w_idx]  <= i_w_tag;
      r_data[i_w_idx] <= i_w_data;
    end
  end

  assign o_r_valid = r_valid[i_r_idx];
  assign o_r_tag   = r_tag[i_r_idx];
  assign o_r_data  = r_data[i_r_idx];
endmodule

// File: rtl/flash_rom_cache.sv
// rtl/flash_rom_cache.sv - ROM read port cache in front of the DSPI flash reader, with next-word prefetch
module flash_rom_cache
  import flash_rom_pkg::*;
#(
  parameter int LINE_BITS = 4,
  parameter bit PREFETCH  = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              ack,
  output logic [DATA_W-1:0] dout,
  input  logic              inval,
  input  logic              flash_ready,
  input  logic              flash_busy,
  input  logic [DATA_W-1:0] flash_dout,
  output logic              flash_cs,
  output logic [ADDR_W-1:0] flash_addr
);
  localparam int TAG_W = ADDR_W - LINE_BITS;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fa, w_fa_nxt, r_pf_addr, w_pf_addr_nxt, r_flash_addr, w_flash_addr_nxt;
  logic              r_demand, w_demand_nxt, r_pf_pend, w_pf_pend_nxt, r_sup, w_sup_nxt;
  logic              r_ack, w_ack_nxt, r_flash_cs, w_flash_cs_nxt;
  logic [DATA_W-1:0] r_dout, w_dout_nxt;

  logic              w_req, w_hit, w_conv, w_we, w_rd_valid;
  logic [ADDR_W-1:0] w_lookup_addr;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [DATA_W-1:0] w_rd_data;

  // req stays high during its own ack cycle, so that cycle must not start a new lookup.
  assign w_req         = req && !r_ack;
  assign w_lookup_addr = w_req ? addr : r_pf_addr;
  assign w_hit         = w_rd_valid && (w_rd_tag == w_lookup_addr[ADDR_W-1:LINE_BITS]);
  assign w_conv        = !r_demand && w_req && (addr == r_fa);
  assign w_we          = (r_state == FILL) && !r_sup;

  rom_cache_mem #(.LINE_BITS(LINE_BITS), .TAG_W(TAG_W)) u_mem (
    .clk      (clk),
    .resetn   (resetn),
    .i_clear  (inval),
    .i_we     (w_we),
    .i_w_idx  (r_fa[LINE_BITS-1:0]),
    .i_w_tag  (r_fa[ADDR_W-1:LINE_BITS]),
    .i_w_data (flash_dout),
    .i_r_idx  (w_lookup_addr[LINE_BITS-1:0]),
    .o_r_valid(w_rd_valid),
    .o_r_tag  (w_rd_tag),
    .o_r_data (w_rd_data)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_fa_nxt         = r_fa;
    w_pf_addr_nxt    = r_pf_addr;
    w_flash_addr_nxt = r_flash_addr;
    w_demand_nxt     = r_demand;
    w_pf_pend_nxt    = r_pf_pend;
    w_sup_nxt        = r_sup;
    w_ack_nxt        = 1'b0;
    w_flash_cs_nxt   = 1'b0;
    w_dout_nxt       = r_dout;
    case (r_state)
      INIT: if (flash_ready) w_state_nxt = IDLE;
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_ack_nxt  = 1'b1;
            w_dout_nxt = w_rd_data;
          end else begin
            w_fa_nxt     = addr;
            w_demand_nxt = 1'b1;
            w_sup_nxt    = 1'b0;
            w_state_nxt  = ISSUE;
          end
        end else if (r_pf_pend) begin
          w_pf_pend_nxt = 1'b0;
          if (!w_hit) begin
            w_fa_nxt     = r_pf_addr;
            w_demand_nxt = 1'b0;
            w_sup_nxt    = 1'b0;
            w_state_nxt  = ISSUE;
          end
        end
      end
      ISSUE: begin
        w_flash_addr_nxt = r_fa;
        if (w_conv) w_demand_nxt = 1'b1;
        if (flash_busy) w_state_nxt = WAIT;
        else            w_flash_cs_nxt = 1'b1;
      end
      WAIT: begin
        if (w_conv) w_demand_nxt = 1'b1;
        if (!flash_busy) w_state_nxt = FILL;
      end
      FILL: begin
        if (r_demand || w_conv) begin
          w_ack_nxt  = 1'b1;
          w_dout_nxt = flash_dout;
          if (PREFETCH) begin
            w_pf_addr_nxt = r_fa + ADDR_W'(1);
            w_pf_pend_nxt = 1'b1;
          end
        end
        w_demand_nxt = 1'b0;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = INIT;
    endcase
    // An in-flight transfer may carry pre-invalidate data, so its fill is dropped.
    if (inval) begin
      w_pf_pend_nxt = 1'b0;
      if (r_state == ISSUE || r_state == WAIT || r_state == FILL) w_sup_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= INIT;
      r_fa         <= '0;
      r_pf_addr    <= '0;
      r_flash_addr <= '0;
      r_demand     <= 1'b0;
      r_pf_pend    <= 1'b0;
      r_sup        <= 1'b0;
      r_ack        <= 1'b0;
      r_flash_cs   <= 1'b0;
      r_dout       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fa         <= w_fa_nxt;
      r_pf_addr    <= w_pf_addr_nxt;
      r_flash_addr <= w_flash_addr_nxt;
      r_demand     <= w_demand_nxt;
      r_pf_pend    <= w_pf_pend_nxt;
      r_sup        <= w_sup_nxt;
      r_ack        <= w_ack_nxt;
      r_flash_cs   <= w_flash_cs_nxt;
      r_dout       <= w_dout_nxt;
    end
  end

  assign ack        = r_ack;
  assign dout       = r_dout;
  assign flash_cs   = r_flash_cs;
  assign flash_addr = r_flash_addr;
endmodule

// File: tb/tb_flash_rom_cache.sv
// tb/tb_flash_rom_cache.sv - directed bench for flash_rom_cache with a behavioural flash reader
module tb_flash_rom_cache;
  logic        clk = 1'b0;
  logic        resetn, req, inval, flash_ready, flash_busy, ack, flash_cs;
  logic [21:0] addr, flash_addr;
  logic [15:0] dout, flash_dout;

  int          total = 0;
  int          bad = 0;
  int          cs_rises = 0;
  logic [21:0] last_cs_addr = '0;
  int          m_cnt;
  logic        m_cs_d;
  logic [21:0] m_addr;

  always #5 clk = ~clk;

  flash_rom_cache #(.LINE_BITS(4), .PREFETCH(1'b1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .addr       (addr),
    .ack        (ack),
    .dout       (dout),
    .inval      (inval),
    .flash_ready(flash_ready),
    .flash_busy (flash_busy),
    .flash_dout (flash_dout),
    .flash_cs   (flash_cs),
    .flash_addr (flash_addr)
  );

  // Flash reader: busy 2 cycles after cs rise, ~32-cycle transfer, data = ~addr[15:0].
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cnt      <= 0;
      m_cs_d     <= 1'b0;
      m_addr     <= '0;
      flash_busy <= 1'b0;
      flash_dout <= '0;
    end else begin
      m_cs_d <= flash_cs;
      if (flash_cs && !m_cs_d && m_cnt == 0) begin
        m_cnt        <= 1;
        m_addr       <= flash_addr;
        cs_rises     <= cs_rises + 1;
        last_cs_addr <= flash_addr;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == 2) flash_busy <= 1'b1;
        if (m_cnt == 33) begin
          flash_busy <= 1'b0;
          flash_dout <= ~m_addr[15:0];
          m_cnt      <= 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [21:0] a, output logic [15:0] d, output int lat);
    req  = 1'b1;
    addr = a;
    lat  = 0;
    d    = 'x;
    while (1) begin
      tick(1);
      lat++;
      if (ack) begin
        d = dout;
        break;
      end
      if (lat >= 200) begin
        chk("rd_timeout", 32'(lat), 32'd0);
        break;
      end
    end
    req = 1'b0;
    tick(1);
  endtask

  task automatic wait_cs(input int n);
    int c = 0;
    while (cs_rises < n && c < 100) begin
      tick(1);
      c++;
    end
    chk("wait_cs_rise", 32'(cs_rises >= n), 32'd1);
  endtask

  task automatic wait_busy();
    int c = 0;
    while (!flash_busy && c < 50) begin
      tick(1);
      c++;
    end
    chk("wait_busy", 32'(flash_busy), 32'd1);
  endtask

  task automatic wait_idle();
    int q = 0;
    int c = 0;
    while (q < 5 && c < 300) begin
      tick(1);
      c++;
      if (!flash_cs && !flash_busy) q++;
      else q = 0;
    end
    chk("wait_idle", 32'(q >= 5), 32'd1);
  endtask

  initial begin
    logic [15:0] d;
    int          lat;
    int          c1;
    logic        seen;

    resetn = 1'b0; req = 1'b0; addr = '0; inval = 1'b0; flash_ready = 1'b0;
    tick(3);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_cs", 32'(flash_cs), 32'd0);
    chk("rst_faddr", 32'(flash_addr), 32'd0);

    // Test 1: cold read, gated by flash_ready, followed by an unrequested prefetch.
    resetn = 1'b1; req = 1'b1; addr = 22'h000100; seen = 1'b0;
    repeat (6) begin
      tick(1);
      if (ack) seen = 1'b1;
    end
    chk("no_ack_before_ready", 32'(seen), 32'd0);
    chk("no_cs_before_ready", 32'(cs_rises), 32'd0);
    flash_ready = 1'b1;
    rd(22'h000100, d, lat);
    chk("cold_dout", 32'(d), 32'hFEFF);
    chk("cold_cs_count", 32'(cs_rises), 32'd1);
    chk("cold_cs_addr", 32'(last_cs_addr), 32'h000100);
    wait_cs(2);
    chk("pf_addr", 32'(last_cs_addr), 32'h000101);

    // Test 3: demand for the word being prefetched joins that transfer.
    rd(22'h000101, d, lat);
    chk("conv_dout", 32'(d), 32'hFEFE);
    chk("conv_no_cs", 32'(cs_rises), 32'd2);
    wait_idle();

    // Test 2: hits return one cycle after req with no flash traffic.
    c1 = cs_rises;
    rd(22'h000100, d, lat);
    chk("hit_lat", 32'(lat), 32'd1);
    chk("hit_dout", 32'(d), 32'hFEFF);
    rd(22'h000102, d, lat);
    chk("pf_hit_lat", 32'(lat), 32'd1);
    chk("pf_hit_dout", 32'(d), 32'hFEFD);
    tick(4);
    chk("hit_no_cs", 32'(cs_rises), 32'(c1));

    // Test 4: prefetch address wraps; same line with another tag misses.
    c1 = cs_rises;
    rd(22'h3FFFFF, d, lat);
    chk("top_dout", 32'(d), 32'h0000);
    chk("top_cs_count", 32'(cs_rises), 32'(c1 + 1));
    wait_cs(c1 + 2);
    chk("wrap_addr", 32'(last_cs_addr), 32'h000000);
    wait_idle();
    c1 = cs_rises;
    rd(22'h000010, d, lat);
    chk("alias_dout", 32'(d), 32'hFFEF);
    chk("alias_miss", 32'(cs_rises), 32'(c1 + 1));
    chk("alias_cs_addr", 32'(last_cs_addr), 32'h000010);
    wait_idle();

    // Test 5: inval during WAIT still acks, but the word is not cached.
    req = 1'b1; addr = 22'h000200;
    wait_busy();
    inval = 1'b1;
    tick(1);
    inval = 1'b0;
    rd(22'h000200, d, lat);
    chk("inval_dout", 32'(d), 32'hFDFF);
    wait_idle();
    c1 = cs_rises;
    rd(22'h000200, d, lat);
    chk("inval_reread_dout", 32'(d), 32'hFDFF);
    chk("inval_reread_slow", 32'(lat > 1), 32'd1);
    wait_idle();
    chk("pf_skip_on_hit", 32'(cs_rises), 32'(c1 + 1));

    // inval in the same cycle as a hit: old data acked, next read misses.
    req = 1'b1; addr = 22'h000200; inval = 1'b1;
    tick(1);
    inval = 1'b0;
    chk("inval_hit_ack", 32'(ack), 32'd1);
    chk("inval_hit_dout", 32'(dout), 32'hFDFF);
    req = 1'b0;
    tick(1);
    c1 = cs_rises;
    rd(22'h000200, d, lat);
    chk("after_inval_miss", 32'(cs_rises), 32'(c1 + 1));
    wait_idle();

    // Test 6: reset mid-WAIT.
    req = 1'b1; addr = 22'h000300;
    wait_busy();
    resetn = 1'b0; flash_ready = 1'b0; req = 1'b0;
    tick(1);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_cs", 32'(flash_cs), 32'd0);
    chk("midrst_faddr", 32'(flash_addr), 32'd0);
    tick(2);
    resetn = 1'b1; req = 1'b1; addr = 22'h000201; seen = 1'b0;
    repeat (6) begin
      tick(1);
      if (ack) seen = 1'b1;
    end
    chk("midrst_no_ack_unready", 32'(seen), 32'd0);
    c1 = cs_rises;
    flash_ready = 1'b1;
    rd(22'h000201, d, lat);
    chk("midrst_dout", 32'(d), 32'hFDFE);
    chk("midrst_valid_cleared", 32'(cs_rises), 32'(c1 + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
